// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the UART TX FIFO write port
// between NUM_REQ byte producers, with a hold timeout for stalled owners.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   fifo_full,
    output logic                   uart_fifo_write_en,
    output logic [7:0]             uart_fifo_data,
    output logic                   grant_valid,
    output logic [2:0]             grant_id,
    output logic                   timeout_pulse,
    output logic [15:0]            tx_count
);

    localparam int HW = ($clog2(HOLD_TIMEOUT + 1) < 1) ? 1 : $clog2(HOLD_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [2:0]      owner, rr_last, pick;
    logic [HW-1:0]   hold_cnt;
    logic [7:0]      valid8, last8;
    logic [63:0]     data64;
    logic            own_valid, own_last, xfer, timeout_fire;
    logic [7:0]      own_data;

    // First valid requester after rr_last, wrapping at NUM_REQ.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] last);
        logic [2:0] sel;
        logic [2:0] cand;
        logic       found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((int'(last) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign valid8    = 8'(req_valid);
    assign last8     = 8'(req_last);
    assign data64    = 64'(req_data);
    assign pick      = rr_pick(valid8, rr_last);
    assign own_valid = valid8[owner];
    assign own_last  = last8[owner];
    assign own_data  = data64[{owner, 3'b000} +: 8];
    assign xfer      = (state == LOCKED) && own_valid && !fifo_full;

    // Backpressure (owner valid, FIFO full) never counts toward the timeout.
    assign timeout_fire = (HOLD_TIMEOUT != 0) && (state == LOCKED) && !own_valid
                          && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = LOCKED;
            LOCKED:  if ((xfer && own_last) || timeout_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready          = '0;
        grant_valid        = 1'b0;
        grant_id           = 3'd0;
        uart_fifo_write_en = 1'b0;
        uart_fifo_data     = 8'd0;
        if (state == LOCKED) begin
            grant_valid        = 1'b1;
            grant_id           = owner;
            uart_fifo_write_en = xfer;
            uart_fifo_data     = own_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (owner == 3'(i)) && own_valid && !fifo_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner         <= 3'd0;
            rr_last       <= 3'(NUM_REQ - 1);
            hold_cnt      <= '0;
            tx_count      <= 16'd0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_fire;
            if (xfer) tx_count <= tx_count + 16'd1;
            if (state == IDLE) begin
                if (|req_valid) begin
                    owner    <= pick;
                    hold_cnt <= '0;
                end
            end else if (xfer) begin
                hold_cnt <= '0;
                if (own_last) rr_last <= owner;
            end else if (!own_valid) begin
                if (timeout_fire) begin
                    rr_last  <= owner;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for interleave and
// round-robin, hand sequences for reset, backpressure, timeout and wrap.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        fifo_full;
    logic        we;
    logic [7:0]  wdata;
    logic        gv;
    logic [2:0]  gid;
    logic        tp;
    logic [15:0] tx_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .HOLD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .uart_fifo_write_en(we), .uart_fifo_data(wdata),
        .grant_valid(gv), .grant_id(gid), .timeout_pulse(tp), .tx_count(tx_count)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        full;
        logic [1:0]  ready;
        logic        we;
        logic [7:0]  wdata;
        logic        gv;
        logic [2:0]  gid;
        logic        tp;
        logic [15:0] tx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l,
                                input logic f, input logic [1:0] r, input logic w,
                                input logic [7:0] wd, input logic g, input logic [2:0] id,
                                input logic t, input logic [15:0] tx);
        vec_t x;
        x.valid = v; x.data = d; x.last = l; x.full = f;
        x.ready = r; x.we = w; x.wdata = wd; x.gv = g; x.gid = id; x.tp = t; x.tx = tx;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            fifo_full = vecs[i].full;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {req_ready, we, wdata, gv, gid, tp, tx_count},
                  {vecs[i].ready, vecs[i].we, vecs[i].wdata, vecs[i].gv, vecs[i].gid,
                   vecs[i].tp, vecs[i].tx});
            tick();
        end
    endtask

    initial begin
        int writes, bad, errs, nwr, idx, cyc, presented;
        logic [7:0] sb[$];
        logic [7:0] exp_b;

        // Interleave "AB" / "XY": 41,42,bubble,58,59
        vecs.push_back(mk(2'b11, 16'h5841, 2'b00, 0, 2'b00, 0, 8'h00, 0, 3'd0, 0, 16'd0));
        vecs.push_back(mk(2'b11, 16'h5841, 2'b00, 0, 2'b01, 1, 8'h41, 1, 3'd0, 0, 16'd0));
        vecs.push_back(mk(2'b11, 16'h5842, 2'b01, 0, 2'b01, 1, 8'h42, 1, 3'd0, 0, 16'd1));
        vecs.push_back(mk(2'b10, 16'h5842, 2'b01, 0, 2'b00, 0, 8'h00, 0, 3'd0, 0, 16'd2));
        vecs.push_back(mk(2'b10, 16'h5842, 2'b00, 0, 2'b10, 1, 8'h58, 1, 3'd1, 0, 16'd2));
        vecs.push_back(mk(2'b10, 16'h5942, 2'b10, 0, 2'b10, 1, 8'h59, 1, 3'd1, 0, 16'd3));
        vecs.push_back(mk(2'b00, 16'h5942, 2'b10, 0, 2'b00, 0, 8'h00, 0, 3'd0, 0, 16'd4));
        // Round robin of single-byte messages: idle row then locked row per message
        for (int m = 0; m < 6; m++) begin
            vecs.push_back(mk(2'b11, 16'hB1A0, 2'b11, 0, 2'b00, 0, 8'h00, 0, 3'd0, 0, 16'(m)));
            if (m % 2 == 0)
                vecs.push_back(mk(2'b11, 16'hB1A0, 2'b11, 0, 2'b01, 1, 8'hA0, 1, 3'd0, 0, 16'(m)));
            else
                vecs.push_back(mk(2'b11, 16'hB1A0, 2'b11, 0, 2'b10, 1, 8'hB1, 1, 3'd1, 0, 16'(m)));
        end

        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        #12;
        check("reset_state", {req_ready, we, wdata, gv, gid, tp, tx_count}, 64'd0);
        tick();
        rst = 1'b1;

        // Reset mid-message with owner 1 and five bytes sent
        req_valid = 2'b10; req_data = 16'h1000; req_last = 2'b00;
        repeat (6) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        check("pre_reset", {gid, tx_count}, {3'd1, 16'd5});
        #1 rst = 1'b0;
        #1;
        check("reset_async", {req_ready, we, wdata, gv, gid, tp, tx_count}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 2'b11; req_data = 16'h1101; req_last = 2'b11;
        @(negedge clk);
        check("reset_idle", {gv, we}, 2'b00);
        tick();
        @(negedge clk);
        check("reset_first_grant", {gv, gid}, {1'b1, 3'd0});
        tick();

        do_reset();
        run_vecs(0, 6);
        do_reset();
        run_vecs(7, 18);
        req_valid = 2'b00;
        @(negedge clk);
        check("rr_tx_count", {gv, tx_count}, {1'b0, 16'd6});
        tick();

        // Backpressure: 50 cycles full, no write, no timeout
        do_reset();
        req_valid = 2'b01; req_data = 16'h0055; req_last = 2'b01; fifo_full = 1'b1;
        writes = 0; bad = 0;
        @(negedge clk);
        tick();
        repeat (50) begin
            @(negedge clk);
            if (we) writes++;
            if (req_ready !== 2'b00 || we !== 1'b0 || gv !== 1'b1 || tp !== 1'b0) bad++;
            tick();
        end
        check("bp_hold", 64'(bad), 64'd0);
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_write", {req_ready, we, wdata}, {2'b01, 1'b1, 8'h55});
        if (we) writes++;
        tick();
        req_valid = 2'b00;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (we) writes++;
            if (tp) bad++;
            tick();
        end
        check("bp_once", 64'(writes), 64'd1);
        check("bp_no_timeout", 64'(bad), 64'd0);

        // Timeout: req1 stalls mid-message, req0 waits
        do_reset();
        req_valid = 2'b10; req_data = 16'h3130; req_last = 2'b01;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("to_first", {we, wdata, gid}, {1'b1, 8'h31, 3'd1});
        tick();
        req_valid = 2'b01;
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (gv !== 1'b1 || gid !== 3'd1 || tp !== 1'b0 || we !== 1'b0) bad++;
            tick();
        end
        check("to_wait", 64'(bad), 64'd0);
        @(negedge clk);
        check("to_release", {gv, tp}, {1'b0, 1'b1});
        tick();
        @(negedge clk);
        check("to_regrant", {gv, gid, tp, we, wdata}, {1'b1, 3'd0, 1'b0, 1'b1, 8'h30});
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("to_pulse_once", {gv, tp}, {1'b0, 1'b0});
        tick();

        // Wrap: 65536 bytes in one message with periodic FIFO-full stalls
        do_reset();
        req_valid = 2'b01; req_last = 2'b00;
        idx = 0; cyc = 0; errs = 0; nwr = 0; presented = -1;
        while (idx < 65536 && cyc < 70000) begin
            fifo_full = (cyc % 97 == 5);
            req_data  = {8'h00, 8'(idx)};
            req_last  = {1'b0, idx == 65535};
            if (presented != idx) begin
                sb.push_back(8'(idx));
                presented = idx;
            end
            @(negedge clk);
            if (tx_count !== 16'(idx)) errs++;
            if (we) begin
                nwr++;
                if (fifo_full) errs++;
                if (sb.size() == 0) errs++;
                else begin
                    exp_b = sb.pop_front();
                    if (wdata !== exp_b) errs++;
                end
            end
            if (req_ready[0]) idx++;
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("wrap_done", 64'(idx), 64'd65536);
        check("wrap_tx_zero", {gv, tx_count}, {1'b0, 16'h0000});
        check("wrap_scoreboard", 64'(errs), 64'd0);
        check("wrap_writes", 64'(nwr), 64'd65536);
        check("wrap_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
